tros_meas_sequencer: RTL and testbench

//   Sequences one frequency-measurement run over the four ring-oscillator counters:

---
 rtl/tros_meas_sequencer_if.sv | 26 ++
 rtl/tros_meas_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tros_meas_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tros_meas_sequencer_if.sv
// Control/status bundle between a run controller and the TROS measurement sequencer.
interface tros_meas_sequencer_if #(
  parameter int GATE_W = 24
);
  logic              start;
  logic              abort;
  logic [3:0]        channel_mask;
  logic [GATE_W-1:0] gate_cycles;
  logic              ctr_reset;
  logic              gate;
  logic              latch_counter;
  logic [1:0]        counter_select;
  logic              frame_active;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, channel_mask, gate_cycles,
    input  ctr_reset, gate, latch_counter, counter_select, frame_active, busy, done
  );

  modport slave (
    input  start, abort, channel_mask, gate_cycles,
    output ctr_reset, gate, latch_counter, counter_select, frame_active, busy, done
  );
endinterface

// File: rtl/tros_meas_sequencer.sv
// Runs one measurement: clear counters, gate window, settle, then latch and
// shift out each enabled ring-oscillator channel in ascending index order.
module tros_meas_sequencer #(
  parameter int COUNTER_LENGTH = 20,
  parameter int RESET_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int GATE_W         = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  tros_meas_sequencer_if.slave ctl
);

  localparam int FRAME_LEN = COUNTER_LENGTH + 4;
  localparam int CNT_MIN   = $clog2(FRAME_LEN + RESET_CYCLES + SETTLE_CYCLES + 1);
  localparam int CNT_W     = (GATE_W > CNT_MIN) ? GATE_W : CNT_MIN;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_SELECT, S_LATCH, S_SHIFT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        rem_q, rem_d;
  logic [GATE_W-1:0] glen_q, glen_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        rem_left;
  logic              abort_hit;

  logic ctr_reset_q, ctr_reset_d;
  logic gate_q, gate_d;
  logic latch_q, latch_d;
  logic frame_q, frame_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      glen_q      <= '0;
      sel_q       <= '0;
      ctr_reset_q <= 1'b0;
      gate_q      <= 1'b0;
      latch_q     <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      glen_q      <= glen_d;
      sel_q       <= sel_d;
      ctr_reset_q <= ctr_reset_d;
      gate_q      <= gate_d;
      latch_q     <= latch_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // cnt_q is loaded with (length-1) on entry to each timed state and exits at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    glen_d    = glen_q;
    abort_hit = 1'b0;
    rem_left  = rem_q & ~(4'b0001 << sel_q);
    case (state_q)
      S_IDLE: begin
        if (ctl.start && !ctl.abort) begin
          glen_d = ctl.gate_cycles;
          rem_d  = ctl.channel_mask;
          if (ctl.channel_mask != 4'd0) begin
            state_d = S_CLEAR;
            cnt_d   = CNT_W'(RESET_CYCLES - 1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = S_GATE;
          // A zero gate length still yields a one-cycle window.
          cnt_d   = (glen_q == '0) ? '0 : CNT_W'(glen_q) - CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SELECT;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_SELECT: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_SHIFT;
        cnt_d   = CNT_W'(FRAME_LEN - 1);
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          rem_d   = rem_left;
          state_d = (rem_left != 4'd0) ? S_SELECT : S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ctl.abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      rem_d     = '0;
      abort_hit = 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    ctr_reset_d = (state_d == S_CLEAR);
    gate_d      = (state_d == S_GATE);
    latch_d     = (state_d == S_LATCH);
    frame_d     = (state_d == S_SHIFT);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_GATE) || (state_d == S_SETTLE) ||
                  (state_d == S_SELECT) || (state_d == S_LATCH) || (state_d == S_SHIFT);
    sel_d       = sel_q;
    if (state_d == S_SELECT) sel_d = lowest_set(rem_d);
    else if (abort_hit)      sel_d = 2'd0;
  end

  assign ctl.ctr_reset      = ctr_reset_q;
  assign ctl.gate           = gate_q;
  assign ctl.latch_counter  = latch_q;
  assign ctl.counter_select = sel_q;
  assign ctl.frame_active   = frame_q;
  assign ctl.busy           = busy_q;
  assign ctl.done           = done_q;

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// Directed bench: each run logs first/last/count of every control output per cycle
// and compares against hand-derived timelines.
module tb_tros_meas_sequencer;
  localparam int GW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tros_meas_sequencer_if #(.GATE_W(GW)) bus ();

  tros_meas_sequencer #(
    .COUNTER_LENGTH(20),
    .RESET_CYCLES  (4),
    .SETTLE_CYCLES (8),
    .GATE_W        (GW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (bus)
  );

  int checks = 0;
  int errors = 0;

  // index: 0 ctr_reset, 1 gate, 2 latch_counter, 3 frame_active, 4 busy, 5 done
  int first_c[6];
  int last_c[6];
  int cnt_c[6];
  int sels[$];
  int sel_err;
  logic [1:0] prev_sel;
  logic [1:0] cur_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 6; i++) begin
      first_c[i] = -1;
      last_c[i]  = -1;
      cnt_c[i]   = 0;
    end
    sels.delete();
    sel_err  = 0;
    prev_sel = bus.counter_select;
    cur_sel  = bus.counter_select;
  endtask

  task automatic record(input int c);
    logic [5:0] s;
    s = {bus.done, bus.busy, bus.frame_active, bus.latch_counter, bus.gate, bus.ctr_reset};
    for (int i = 0; i < 6; i++) begin
      if (s[i]) begin
        if (first_c[i] < 0) first_c[i] = c;
        last_c[i] = c;
        cnt_c[i]++;
      end
    end
    if (bus.latch_counter) begin
      sels.push_back(int'(bus.counter_select));
      if (bus.counter_select !== prev_sel) sel_err++;
      cur_sel = bus.counter_select;
    end
    if (bus.frame_active && (bus.counter_select !== cur_sel)) sel_err++;
    prev_sel = bus.counter_select;
  endtask

  // start is driven during cycle 0; inputs for cycle c are applied just after edge c.
  task automatic run(input logic [3:0] m, input int g, input int ncyc,
                     input int start_cyc, input int abort_cyc, input int rst_cyc);
    clear_stats();
    @(negedge clk);
    bus.channel_mask = m;
    bus.gate_cycles  = GW'(g);
    bus.start        = 1'b1;
    bus.abort        = (abort_cyc == 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start        = (c == start_cyc);
      bus.abort        = (c == abort_cyc);
      rst_n            = !((c == rst_cyc) || (c == rst_cyc + 1));
      bus.channel_mask = ~m;
      bus.gate_cycles  = GW'(3);
      @(negedge clk);
      record(c);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic expect_span(input string name, input int idx, input int f, input int l, input int n);
    check({name, "_first"}, first_c[idx], f);
    check({name, "_last"},  last_c[idx],  l);
    check({name, "_count"}, cnt_c[idx],   n);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.channel_mask = 4'd0;
    bus.gate_cycles  = '0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctr_reset", bus.ctr_reset, 0);
    check("rst_gate", bus.gate, 0);
    check("rst_latch", bus.latch_counter, 0);
    check("rst_select", bus.counter_select, 0);
    check("rst_frame", bus.frame_active, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single channel, start pulsed again during DONE must be ignored
    run(4'b0001, 100, 160, 139, -1, -1);
    expect_span("t2_ctr", 0, 1, 4, 4);
    expect_span("t2_gate", 1, 5, 104, 100);
    expect_span("t2_latch", 2, 114, 114, 1);
    expect_span("t2_frame", 3, 115, 138, 24);
    expect_span("t2_busy", 4, 1, 138, 138);
    expect_span("t2_done", 5, 139, 139, 1);
    check("t2_sel0", sels[0], 0);
    check("t2_sel_stable", sel_err, 0);

    // start mid-run ignored
    run(4'b0001, 100, 150, 30, -1, -1);
    expect_span("t5b_ctr", 0, 1, 4, 4);
    expect_span("t5b_latch", 2, 114, 114, 1);
    expect_span("t5b_done", 5, 139, 139, 1);

    // two sparse channels
    run(4'b1010, 10, 90, -1, -1, -1);
    expect_span("t3_ctr", 0, 1, 4, 4);
    expect_span("t3_gate", 1, 5, 14, 10);
    expect_span("t3_latch", 2, 24, 50, 2);
    expect_span("t3_frame", 3, 25, 74, 48);
    expect_span("t3_done", 5, 75, 75, 1);
    check("t3_nsel", sels.size(), 2);
    check("t3_sel_a", sels[0], 1);
    check("t3_sel_b", sels[1], 3);
    check("t3_sel_stable", sel_err, 0);

    // zero gate length behaves as one
    run(4'b0001, 0, 50, -1, -1, -1);
    expect_span("t4_gate", 1, 5, 5, 1);
    expect_span("t4_latch", 2, 15, 15, 1);
    expect_span("t4_done", 5, 40, 40, 1);

    // empty mask goes straight to done
    run(4'b0000, 100, 10, -1, -1, -1);
    expect_span("t4m_done", 5, 1, 1, 1);
    check("t4m_ctr_count", cnt_c[0], 0);
    check("t4m_gate_count", cnt_c[1], 0);
    check("t4m_busy_count", cnt_c[4], 0);

    // abort during gate
    run(4'b0001, 100, 130, -1, 50, -1);
    expect_span("t5_gate", 1, 5, 50, 46);
    expect_span("t5_busy", 4, 1, 50, 50);
    check("t5_latch_count", cnt_c[2], 0);
    check("t5_frame_count", cnt_c[3], 0);
    check("t5_done_count", cnt_c[5], 0);

    // abort together with start in IDLE wins
    run(4'b0001, 100, 20, -1, 0, -1);
    check("as_ctr_count", cnt_c[0], 0);
    check("as_busy_count", cnt_c[4], 0);
    check("as_done_count", cnt_c[5], 0);

    // reset mid-shift
    run(4'b0001, 100, 150, -1, -1, 120);
    expect_span("t1_frame", 3, 115, 120, 6);
    expect_span("t1_busy", 4, 1, 120, 120);
    check("t1_done_count", cnt_c[5], 0);

    run(4'b0001, 100, 145, -1, -1, -1);
    expect_span("t1b_frame", 3, 115, 138, 24);
    expect_span("t1b_done", 5, 139, 139, 1);

    // all channels, maximum gate value
    run(4'b1111, (1 << GW) - 1, 4230, -1, -1, -1);
    expect_span("t6_gate", 1, 5, 4099, 4095);
    expect_span("t6_latch", 2, 4109, 4187, 4);
    expect_span("t6_frame", 3, 4110, 4211, 96);
    expect_span("t6_done", 5, 4212, 4212, 1);
    check("t6_nsel", sels.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t6_sel%0d", i), sels[i], i);
    check("t6_sel_stable", sel_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
